tx_frame_ctrl: RTL and testbench
================================

// Module: tx_frame_ctrl
// PURPOSE
//  Frame sequencer between the transmit byte buffer and the tri-mode Ethernet
//  MAC AXI4-Stream TX port. Builds each frame from a 14-byte header (dst MAC,
//  src MAC, length/type), followed by a payload pulled from the byte buffer.
//  It drives tlast on the final byte, inserts a programmable inter-frame gap,
//  and runs back-to-back frames while enabled.
// PARAMETERS
//  IFG_CYCLES  12    idle cycles in GAP after each frame's tlast handshake (0 = no gap)
//  MIN_LEN     46    minimum payload length, bytes
//  MAX_LEN     1500  maximum payload length, bytes
//  CNT_W       16    width of frame_cnt
// PORTS
//  clk            in   1      clock
//  rst_n          in   1      reset, asynchronous assert, active-low
//  enable         in   1      level; high = generate frames continuously
//  frame_len      in   11     payload length request, sampled at frame start
//  dst_mac        in   48     destination MAC, sampled at frame start
//  src_mac        in   48     source MAC, sampled at frame start
//  fifo_valid     in   1      byte buffer has data
//  fifo_data      in   8      byte buffer data, valid with fifo_valid
//  fifo_ready     out  1      pop strobe to byte buffer
//  m_axis_tdata   out  8      MAC TX data
//  m_axis_tvalid  out  1      MAC TX valid
//  m_axis_tlast   out  1      MAC TX last byte of frame
//  m_axis_tready  in   1      MAC TX ready
//  busy           out  1      state != IDLE
//  frame_done     out  1      1-cycle pulse, cycle after tlast handshake
//  frame_cnt      out  CNT_W  frames completed, wraps at 2^CNT_W-1 -> 0
//  underrun       out  1      sticky; set on payload starvation, cleared only by reset
// BEHAVIOUR
//  Clock and reset: one clock, clk; rst_n is asynchronous, active-low.
//  Reset state: state=IDLE, all counters 0, latched fields 0.
//  Reset outputs: every output is 0.
//  Reset mid-frame aborts immediately; no tlast is emitted.
//  FSM states: IDLE -> HDR -> PAYLOAD -> GAP -> (HDR | IDLE).
//  IDLE: when enable=1, latch dst_mac, src_mac and the clamped length, then go
//   to HDR next cycle. Clamped length L = max(MIN_LEN, min(MAX_LEN, frame_len)).
//  HDR: tvalid=1; byte index h runs 0..13.
//   Bytes 0-5: dst_mac[47:0], MSB first.
//   Bytes 6-11: src_mac, MSB first.
//   Bytes 12-13: L[15:8], L[7:0] (L zero-extended to 16 bits).
//   h advances only on tvalid&tready; tdata is held stable while tready=0.
//   After the byte-13 handshake, go to PAYLOAD.
//  PAYLOAD: combinational pass-through.
//   tvalid = fifo_valid; tdata = fifo_data; fifo_ready = m_axis_tready.
//   A byte moves only on fifo_valid & tready; payload counter p counts 0..L-1.
//   tlast = (p == L-1) & tvalid. After the tlast handshake, go to GAP.
//   fifo_ready=0 in every state other than PAYLOAD.
//  Underrun: fifo_valid=0 while tready=1 in PAYLOAD sets the underrun flag.
//   The frame stalls (tvalid low) and is not truncated.
//  GAP: tvalid=0 for exactly IFG_CYCLES cycles.
//   If IFG_CYCLES=0, GAP lasts 1 cycle to evaluate enable.
//   On exit: enable=1 -> re-latch fields, go to HDR; enable=0 -> IDLE.
//  frame_done and frame_cnt update in the first GAP cycle.
//  Deasserting enable mid-frame has no effect until GAP exit: the frame
//   always completes.
//  Changes to frame_len, dst_mac or src_mac mid-frame are ignored until the
//   next latch.
//  AXI rules: once tvalid=1 in HDR, tvalid and tdata are held until handshake.
//   In PAYLOAD, tvalid validity follows the byte buffer's own valid/ready rules.
//  Latency: enable rise to first tvalid = 1 cycle; header = 14 handshakes.
// TESTING
//  T1 reset: assert rst_n=0 asynchronously mid-PAYLOAD -> all outputs 0
//   immediately; after release, stays IDLE with enable=0.
//  T2 basic frame: frame_len=46, dst=0x0011_2233_4455, src=0xAABB_CCDD_EEFF,
//   fifo bytes 0..45, tready=1 -> bytes 00 11 22 33 44 55 AA BB CC DD EE FF
//   00 2E, then 00..2D with tlast on 0x2D; frame_done 1 cycle later;
//   frame_cnt=1.
//  T3 clamp: frame_len=10 -> L=46, length bytes 00 2E;
//   frame_len=2000 -> L=1500, length bytes 05 DC, tlast on byte 1500.
//  T4 backpressure: random tready (50%) -> tdata/tvalid stable while
//   tready=0; byte order and count identical to T2.
//  T5 underrun + gap: drop fifo_valid for 5 cycles at payload byte 20 ->
//   underrun=1 sticky, frame still 60 bytes total; with enable held high,
//   exactly 12 idle cycles between tlast handshake and next header byte.
//  T6 enable drop: deassert enable at header byte 3 -> frame completes
//   fully; after GAP, FSM is IDLE and busy=0.

Source files
------------

// File: rtl/tx_frame_ctrl.sv
// Frame sequencer: 14-byte Ethernet header followed by a byte-buffer payload onto
// an AXI4-Stream byte port, with tlast, inter-frame gap and back-to-back frames.
module tx_frame_ctrl #(
    parameter int unsigned IFG_CYCLES = 12,
    parameter int unsigned MIN_LEN    = 46,
    parameter int unsigned MAX_LEN    = 1500,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable_i,
    input  logic [10:0]      frame_len_i,
    input  logic [47:0]      dst_mac_i,
    input  logic [47:0]      src_mac_i,
    input  logic             fifo_valid_i,
    input  logic [7:0]       fifo_data_i,
    output logic             fifo_ready_o,
    output logic [7:0]       m_axis_tdata_o,
    output logic             m_axis_tvalid_o,
    output logic             m_axis_tlast_o,
    input  logic             m_axis_tready_i,
    output logic             busy_o,
    output logic             frame_done_o,
    output logic [CNT_W-1:0] frame_cnt_o,
    output logic             underrun_o
);

    // state   | meaning
    // IDLE    | waiting for enable; frame fields latched on exit
    // HDR     | sending dst MAC, src MAC, length (14 bytes)
    // PAYLOAD | passing L bytes from the byte buffer to the MAC
    // GAP     | inter-frame idle; chooses HDR or IDLE on exit
    typedef enum logic [1:0] {S_IDLE, S_HDR, S_PAYLOAD, S_GAP} state_t;

    localparam logic [10:0] MIN_L    = 11'(MIN_LEN);
    localparam logic [10:0] MAX_L    = 11'(MAX_LEN);
    localparam logic [15:0] GAP_LOAD = (IFG_CYCLES == 0) ? 16'd0 : 16'(IFG_CYCLES - 1);

    state_t           state_q, state_d;
    logic [47:0]      dst_q, dst_d, src_q, src_d;
    logic [10:0]      len_q, len_d, pcnt_q, pcnt_d;
    logic [3:0]       hidx_q, hidx_d;
    logic [15:0]      gap_q, gap_d;
    logic             done_q, done_d, urun_q, urun_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [10:0]  len_clamp;
    logic [111:0] hdr_bits;
    logic [6:0]   hsel;
    logic         last_byte;
    logic         latch;

    assign len_clamp = (frame_len_i < MIN_L) ? MIN_L :
                       (frame_len_i > MAX_L) ? MAX_L : frame_len_i;
    assign hdr_bits  = {dst_q, src_q, 5'd0, len_q};
    assign hsel      = 7'd111 - {hidx_q, 3'b000};
    assign last_byte = (pcnt_q == len_q - 11'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            dst_q   <= '0;
            src_q   <= '0;
            len_q   <= '0;
            pcnt_q  <= '0;
            hidx_q  <= '0;
            gap_q   <= '0;
            done_q  <= 1'b0;
            urun_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            dst_q   <= dst_d;
            src_q   <= src_d;
            len_q   <= len_d;
            pcnt_q  <= pcnt_d;
            hidx_q  <= hidx_d;
            gap_q   <= gap_d;
            done_q  <= done_d;
            urun_q  <= urun_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        dst_d           = dst_q;
        src_d           = src_q;
        len_d           = len_q;
        pcnt_d          = pcnt_q;
        hidx_d          = hidx_q;
        gap_d           = gap_q;
        done_d          = 1'b0;
        urun_d          = urun_q;
        cnt_d           = cnt_q;
        latch           = 1'b0;
        m_axis_tvalid_o = 1'b0;
        m_axis_tdata_o  = 8'h00;
        m_axis_tlast_o  = 1'b0;
        fifo_ready_o    = 1'b0;

        case (state_q)
            S_IDLE: begin
                latch = enable_i;
            end
            S_HDR: begin
                m_axis_tvalid_o = 1'b1;
                m_axis_tdata_o  = hdr_bits[hsel -: 8];
                if (m_axis_tready_i) begin
                    if (hidx_q == 4'd13) begin
                        state_d = S_PAYLOAD;
                        pcnt_d  = '0;
                        hidx_d  = '0;
                    end else begin
                        hidx_d = hidx_q + 4'd1;
                    end
                end
            end
            S_PAYLOAD: begin
                m_axis_tvalid_o = fifo_valid_i;
                m_axis_tdata_o  = fifo_data_i;
                m_axis_tlast_o  = last_byte & fifo_valid_i;
                fifo_ready_o    = m_axis_tready_i;
                // starvation only counts when the MAC was actually asking for a byte
                if (!fifo_valid_i && m_axis_tready_i) begin
                    urun_d = 1'b1;
                end
                if (fifo_valid_i && m_axis_tready_i) begin
                    if (last_byte) begin
                        state_d = S_GAP;
                        gap_d   = GAP_LOAD;
                        done_d  = 1'b1;
                        cnt_d   = cnt_q + CNT_W'(1);
                    end else begin
                        pcnt_d = pcnt_q + 11'd1;
                    end
                end
            end
            S_GAP: begin
                if (gap_q == 16'd0) begin
                    latch   = enable_i;
                    state_d = S_IDLE;
                end else begin
                    gap_d = gap_q - 16'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (latch) begin
            state_d = S_HDR;
            dst_d   = dst_mac_i;
            src_d   = src_mac_i;
            len_d   = len_clamp;
            hidx_d  = '0;
        end
    end

    assign busy_o       = (state_q != S_IDLE);
    assign frame_done_o = done_q;
    assign frame_cnt_o  = cnt_q;
    assign underrun_o   = urun_q;

endmodule

// File: tb/tb_tx_frame_ctrl.sv
// Randomized scoreboard bench for tx_frame_ctrl: a frame model queues expected
// bytes, a monitor pops and compares on every AXI handshake.
module tb_tx_frame_ctrl;

    localparam int IFG    = 12;
    localparam int BUDGET = 20000;

    logic        clk, rst_n, enable;
    logic [10:0] frame_len;
    logic [47:0] dst_mac, src_mac;
    logic        fifo_valid;
    logic [7:0]  fifo_data;
    logic        fifo_ready;
    logic [7:0]  tdata;
    logic        tvalid, tlast, tready;
    logic        busy, frame_done, underrun;
    logic [15:0] frame_cnt;

    tx_frame_ctrl dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .enable_i        (enable),
        .frame_len_i     (frame_len),
        .dst_mac_i       (dst_mac),
        .src_mac_i       (src_mac),
        .fifo_valid_i    (fifo_valid),
        .fifo_data_i     (fifo_data),
        .fifo_ready_o    (fifo_ready),
        .m_axis_tdata_o  (tdata),
        .m_axis_tvalid_o (tvalid),
        .m_axis_tlast_o  (tlast),
        .m_axis_tready_i (tready),
        .busy_o          (busy),
        .frame_done_o    (frame_done),
        .frame_cnt_o     (frame_cnt),
        .underrun_o      (underrun)
    );

    int checks = 0;
    int errors = 0;

    logic [8:0] exp_q[$];
    logic [7:0] byte_q[$];
    int         frame_start_q[$];
    int         exp_pushed_total = 0;

    // feeder / ready generator state
    bit bp_mode = 0;
    int starve_at = -1;
    int starve_left = 0;
    int popped_total = 0;

    // monitor state
    int hs_count = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #900000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference frame: header bytes from the fields, clamped length, payload bytes.
    task automatic set_fields(input logic [47:0] d, input logic [47:0] s,
                              input logic [10:0] fl, input bit counting);
        int          len;
        logic [15:0] lw;
        logic [7:0]  b;
        dst_mac   = d;
        src_mac   = s;
        frame_len = fl;
        len = int'(fl);
        if (len < 46) len = 46;
        if (len > 1500) len = 1500;
        lw = 16'(len);
        frame_start_q.push_back(exp_pushed_total);
        for (int i = 0; i < 6; i++) exp_q.push_back({1'b0, d[47-8*i -: 8]});
        for (int i = 0; i < 6; i++) exp_q.push_back({1'b0, s[47-8*i -: 8]});
        exp_q.push_back({1'b0, lw[15:8]});
        exp_q.push_back({1'b0, lw[7:0]});
        for (int p = 0; p < len; p++) begin
            b = counting ? 8'(p) : 8'($urandom);
            exp_q.push_back({(p == len - 1), b});
            byte_q.push_back(b);
        end
        exp_pushed_total += 14 + len;
    endtask

    task automatic set_rand(input int maxlen);
        logic [47:0] d, s;
        d = {16'($urandom), 32'($urandom)};
        s = {16'($urandom), 32'($urandom)};
        set_fields(d, s, 11'($urandom_range(0, maxlen)), 1'b0);
    endtask

    task automatic wait_hs(input int target, input string name);
        bit hit = 0;
        for (int i = 0; i < BUDGET && !hit; i++) begin
            @(negedge clk);
            if (hs_count >= target) hit = 1;
        end
        if (!hit) begin
            checks++; errors++;
            $display("FAIL %s: timeout waiting for handshake %0d (have %0d)", name, target, hs_count);
        end
        @(posedge clk); #1;
    endtask

    // Waits for the last frame's done pulse, then checks the gap length by busy.
    task automatic wait_done_idle(input string name);
        bit hit = 0;
        for (int i = 0; i < BUDGET && !hit; i++) begin
            @(negedge clk);
            if (frame_done) hit = 1;
        end
        if (!hit) begin
            checks++; errors++;
            $display("FAIL %s_done: timeout waiting for frame_done, got 0 expected 1", name);
        end
        repeat (IFG - 1) @(negedge clk);
        chk({name, "_gap_busy"}, 64'(busy), 64'd1);
        @(negedge clk);
        chk({name, "_idle_busy"}, 64'(busy), 64'd0);
        repeat (3) @(negedge clk);
        chk({name, "_idle_tvalid"}, 64'(tvalid), 64'd0);
    endtask

    // First frame's fields must already be set. Enable drops at header byte 3 of the last.
    task automatic run_frames(input int n, input int maxlen, input string name);
        int base;
        @(posedge clk); #1;
        enable = 1'b1;
        for (int k = 0; k < n; k++) begin
            base = frame_start_q.pop_front();
            if (k < n - 1) begin
                wait_hs(base + 1, name);
                set_rand(maxlen);
            end else begin
                wait_hs(base + 4, name);
                enable = 1'b0;
            end
        end
        wait_done_idle(name);
    endtask

    // byte buffer model and MAC ready generator
    initial begin : feeder
        bit pop;
        fifo_valid = 1'b0;
        fifo_data  = 8'h00;
        tready     = 1'b1;
        forever begin
            @(negedge clk);
            pop = fifo_valid && fifo_ready && rst_n;
            @(posedge clk); #1;
            if (pop && byte_q.size() > 0) begin
                void'(byte_q.pop_front());
                popped_total++;
            end
            if (starve_at == popped_total && starve_left > 0) begin
                fifo_valid = 1'b0;
                starve_left--;
            end else begin
                fifo_valid = (byte_q.size() > 0);
            end
            fifo_data = (byte_q.size() > 0) ? byte_q[0] : 8'h00;
            tready    = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin : monitor
        int         cyc = 0, tlast_cyc = 0, exp_frames = 0;
        bit         exp_done = 0, gap_track = 0, gap_armed = 0, prev_stall = 0;
        logic [7:0] prev_data = 8'h00;
        logic [8:0] e;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                hs_count = 0; exp_frames = 0; exp_done = 0;
                gap_track = 0; prev_stall = 0;
            end else begin
                if (exp_done || frame_done) chk("frame_done", 64'(frame_done), 64'(exp_done));
                if (exp_done) chk("frame_cnt", 64'(frame_cnt), 64'(16'(exp_frames)));
                exp_done = 0;
                if (prev_stall) begin
                    chk("stall_tvalid", 64'(tvalid), 64'd1);
                    chk("stall_tdata", 64'(tdata), 64'(prev_data));
                end
                if (tvalid && gap_track) begin
                    gap_track = 0;
                    if (gap_armed) chk("ifg_cycles", 64'(cyc - tlast_cyc - 1), 64'(IFG));
                end
                if (tvalid && tready) begin
                    hs_count++;
                    if (exp_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_byte: got %0h expected no transfer", {tlast, tdata});
                    end else begin
                        e = exp_q.pop_front();
                        chk("byte", 64'({tlast, tdata}), 64'(e));
                    end
                    if (tlast) begin
                        exp_frames++;
                        exp_done  = 1;
                        tlast_cyc = cyc;
                        gap_track = 1;
                        gap_armed = enable;
                    end
                end
                prev_stall = tvalid && !tready;
                prev_data  = tdata;
            end
        end
    end

    initial begin : scenario
        int base;
        rst_n = 1'b0; enable = 1'b0; frame_len = '0; dst_mac = '0; src_mac = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("por_outputs", 64'({tvalid, tlast, tdata, fifo_ready, busy, frame_done, frame_cnt, underrun}), 64'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("idle_busy", 64'(busy), 64'd0);
        chk("idle_tvalid", 64'(tvalid), 64'd0);

        // basic frame with known fields and counting payload
        set_fields(48'h0011_2233_4455, 48'hAABB_CCDD_EEFF, 11'd46, 1'b1);
        run_frames(1, 0, "t2");
        chk("t2_cnt", 64'(frame_cnt), 64'd1);

        // length clamping, both ends
        set_rand(0);
        set_fields(dst_mac, src_mac, 11'd10, 1'b0);
        void'(frame_start_q.pop_back());
        begin
            // set_rand already queued a frame; rebuild with an explicit short length
            exp_q.delete(); byte_q.delete(); exp_pushed_total = hs_count;
            frame_start_q.delete();
            set_fields(48'h0102_0304_0506, 48'h0A0B_0C0D_0E0F, 11'd10, 1'b0);
        end
        run_frames(1, 0, "t3_min");
        set_fields(48'hFFEE_DDCC_BBAA, 48'h1234_5678_9ABC, 11'd2000, 1'b0);
        run_frames(1, 0, "t3_max");
        chk("t3_cnt", 64'(frame_cnt), 64'd3);

        // random backpressure, back-to-back random frames
        bp_mode = 1;
        set_rand(300);
        run_frames(3, 300, "t4");
        bp_mode = 0;
        chk("t4_underrun", 64'(underrun), 64'd0);

        // starvation at payload byte 20, then a back-to-back frame
        starve_at   = popped_total + 20;
        starve_left = 5;
        set_fields(48'h0000_0000_0001, 48'h0000_0000_0002, 11'd46, 1'b1);
        run_frames(2, 120, "t5");
        chk("t5_underrun", 64'(underrun), 64'd1);
        chk("t5_cnt", 64'(frame_cnt), 64'd8);

        // reset in the middle of a payload
        set_rand(200);
        @(posedge clk); #1 enable = 1'b1;
        base = frame_start_q.pop_front();
        wait_hs(base + 34, "t1");
        #3 rst_n = 1'b0;
        #1;
        chk("rst_outputs", 64'({tvalid, tlast, tdata, fifo_ready, busy, frame_done, frame_cnt, underrun}), 64'd0);
        enable = 1'b0;
        exp_q.delete(); byte_q.delete(); frame_start_q.delete();
        exp_pushed_total = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("t1_busy", 64'(busy), 64'd0);
        chk("t1_tvalid", 64'(tvalid), 64'd0);
        chk("t1_underrun", 64'(underrun), 64'd0);
        chk("t1_cnt", 64'(frame_cnt), 64'd0);

        set_rand(100);
        run_frames(1, 0, "post_rst");
        chk("post_rst_cnt", 64'(frame_cnt), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
